exe_stage: RTL and testbench
============================

// Module: exe_stage
// PURPOSE
//   Execute stage of the 5-stage pipeline, directly upstream of the memory stage.
//   - Latches the decode-stage bundle into the ID/EX register.
//   - Computes the ALU result from the latched operands and presents ex_* signals to the memory stage.
//   - Runs an iterative shift-add multiplier for MUL and stalls decode while it is busy.
// PARAMETERS
//   DW          32   datapath width; ALU, multiplier and operand width
//   ENABLE_MUL  1    1: aluc=12 runs the iterative multiply; 0: aluc=12 behaves as ADD, no stall
// PORTS
//   clk             in   1   pipeline clock; all state updates on rising edge
//   rst             in   1   asynchronous, active-low reset
//   id_destR        in   5   destination register number from decode
//   id_inA          in   DW  operand A (register rs value)
//   id_inB          in   DW  operand B (register rt value; also store data)
//   id_imm          in   DW  sign/zero-extended immediate
//   id_aluc         in   4   ALU opcode (encoding in BEHAVIOUR)
//   id_aluimm       in   1   1: ALU operand B = id_imm; 0: ALU operand B = id_inB
//   id_wreg         in   1   instruction writes the register file
//   id_m2reg        in   1   write-back value comes from memory
//   id_wmem         in   1   instruction writes data memory
//   ID_ins_type     in   4   instruction-type tag, for the debug display
//   ID_ins_number   in   4   instruction-sequence tag, for the debug display
//   ex_destR        out  5   latched destination register
//   ex_inB          out  DW  latched id_inB (store data); never replaced by the immediate
//   ex_aluR         out  DW  ALU or multiply result; combinational from latched state
//   ex_wreg         out  1   latched wreg, masked to 0 while multiplying
//   ex_m2reg        out  1   latched m2reg, masked to 0 while multiplying
//   ex_wmem         out  1   latched wmem, masked to 0 while multiplying
//   EXE_ins_type    out  4   latched type tag (not masked)
//   EXE_ins_number  out  4   latched number tag (not masked)
//   ex_stall        out  1   1: decode must hold its outputs; the ID/EX register does not load
// BEHAVIOUR
//   - Reset (rst=0, asynchronous): ID/EX register, multiplier accumulator and counter all clear to 0.
//     All outputs are 0, which makes the latched instruction a NOP (ADD 0+0, no writes). ex_stall=0.
//   - Load: on each rising edge with ex_stall=0, the ID/EX register loads all id_* and ID_* inputs.
//     With ex_stall=1, the register holds its value and the id_* inputs are ignored.
//   - Operands: A = latched inA; B = latched aluimm ? imm : inB.
//   - ALU: combinational on the latched values, so ex_aluR is valid in the same cycle the instruction
//     is latched (1-cycle latency from the load edge).
//   - aluc encoding:
//       0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR,
//       6 SLT (signed compare, result 1/0), 7 SLTU (unsigned compare, result 1/0),
//       8 SLL (B<<A[4:0]), 9 SRL (B>>A[4:0], logical), 10 SRA (B>>>A[4:0], arithmetic),
//       11 LUI ({B[15:0],16'b0}), 12 MUL, 13-15 ADD.
//   - Arithmetic: ADD and SUB wrap modulo 2^DW; no overflow flag and no exception.
//   - MUL state machine, two states:
//       IDLE -> BUSY: when a MUL is latched; counter=0, accumulator=0.
//       BUSY: one shift-add step per edge, unsigned, low DW bits kept. Counter runs 0..DW-1.
//       BUSY -> IDLE: on the DW-th step; the done flag is set.
//   - MUL timing:
//       ex_stall=1 for exactly DW cycles, starting in the load cycle.
//       ex_wreg, ex_m2reg and ex_wmem read 0 during those cycles, so MEM sees bubbles.
//       Cycle DW after the load: ex_aluR=product[DW-1:0], controls unmasked, ex_stall=0.
//       The next edge loads the following instruction. A MUL therefore occupies EX for DW+1 cycles.
//   - Back-to-back MULs: the second MUL restarts from IDLE; its stall is not shortened.
//   - Reset during BUSY: the multiply is abandoned and the stage returns to NOP/IDLE at once.
//   - ENABLE_MUL=0: no BUSY state; ex_stall is tied to 0.
// TESTING
//   1. Reset: hold rst=0 with random id_*, then release -> all outputs 0 and ex_stall=0 until the first edge.
//   2. ADD with imm: inA=32'h7FFFFFFF, imm=1, aluimm=1 -> ex_aluR=32'h80000000 after 1 edge, ex_inB=id_inB.
//   3. Compares and shifts:
//        SLT  A=-1, B=1          -> 1
//        SLTU A=-1, B=1          -> 0
//        SRA  B=32'h80000000, A=4 -> 32'hF8000000
//        LUI  imm=16'h1234        -> 32'h12340000
//   4. MUL 1234*5678 followed by ADD: ex_stall=1 for exactly 32 cycles with ex_wreg=0 throughout,
//      then ex_aluR=7006652, ex_wreg=1, and the ADD is latched on the following edge.
//   5. Reset mid-MUL: assert rst=0 at busy cycle 10 -> outputs 0 and ex_stall=0 asynchronously;
//      the next MUL still takes the full 32 stall cycles.
//   6. Store passthrough: aluimm=1, wmem=1, inB=32'hDEADBEEF -> ex_inB=32'hDEADBEEF, ex_wmem=1,
//      ex_aluR=inA+imm.

Source files
------------

// File: rtl/exe_stage.sv
// Execute stage: ID/EX pipeline register, combinational ALU and an iterative
// shift-add multiplier that holds decode while a MUL is in flight.
module exe_stage #(
  parameter int DW         = 32,
  parameter int ENABLE_MUL = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    id_destR,
  input  logic [DW-1:0] id_inA,
  input  logic [DW-1:0] id_inB,
  input  logic [DW-1:0] id_imm,
  input  logic [3:0]    id_aluc,
  input  logic          id_aluimm,
  input  logic          id_wreg,
  input  logic          id_m2reg,
  input  logic          id_wmem,
  input  logic [3:0]    ID_ins_type,
  input  logic [3:0]    ID_ins_number,
  output logic [4:0]    ex_destR,
  output logic [DW-1:0] ex_inB,
  output logic [DW-1:0] ex_aluR,
  output logic          ex_wreg,
  output logic          ex_m2reg,
  output logic          ex_wmem,
  output logic [3:0]    EXE_ins_type,
  output logic [3:0]    EXE_ins_number,
  output logic          ex_stall
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  logic [4:0]    dest_reg;
  logic [DW-1:0] ina_reg;
  logic [DW-1:0] inb_reg;
  logic [DW-1:0] imm_reg;
  logic [3:0]    aluc_reg;
  logic          aluimm_reg;
  logic          wreg_reg;
  logic          m2reg_reg;
  logic          wmem_reg;
  logic [3:0]    type_reg;
  logic [3:0]    num_reg;

  logic [DW-1:0] a_op;
  logic [DW-1:0] b_op;
  logic [DW-1:0] alu_result;
  logic [DW-1:0] mul_result;
  logic          mul_stall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dest_reg   <= '0;
      ina_reg    <= '0;
      inb_reg    <= '0;
      imm_reg    <= '0;
      aluc_reg   <= '0;
      aluimm_reg <= 1'b0;
      wreg_reg   <= 1'b0;
      m2reg_reg  <= 1'b0;
      wmem_reg   <= 1'b0;
      type_reg   <= '0;
      num_reg    <= '0;
    end else if (!mul_stall) begin
      dest_reg   <= id_destR;
      ina_reg    <= id_inA;
      inb_reg    <= id_inB;
      imm_reg    <= id_imm;
      aluc_reg   <= id_aluc;
      aluimm_reg <= id_aluimm;
      wreg_reg   <= id_wreg;
      m2reg_reg  <= id_m2reg;
      wmem_reg   <= id_wmem;
      type_reg   <= ID_ins_type;
      num_reg    <= ID_ins_number;
    end
  end

  assign a_op = ina_reg;
  assign b_op = aluimm_reg ? imm_reg : inb_reg;

  always_comb begin
    alu_result = a_op + b_op;
    case (aluc_reg)
      4'd1:  alu_result = a_op - b_op;
      4'd2:  alu_result = a_op & b_op;
      4'd3:  alu_result = a_op | b_op;
      4'd4:  alu_result = a_op ^ b_op;
      4'd5:  alu_result = ~(a_op | b_op);
      4'd6:  alu_result = ($signed(a_op) < $signed(b_op)) ? DW'(1) : '0;
      4'd7:  alu_result = (a_op < b_op) ? DW'(1) : '0;
      4'd8:  alu_result = b_op << a_op[4:0];
      4'd9:  alu_result = b_op >> a_op[4:0];
      4'd10: alu_result = $signed(b_op) >>> a_op[4:0];
      4'd11: alu_result = {b_op[DW-17:0], 16'b0};
      4'd12: alu_result = (ENABLE_MUL != 0) ? mul_result : (a_op + b_op);
      default: alu_result = a_op + b_op;
    endcase
  end

  generate
    if (ENABLE_MUL != 0) begin : g_mul
      localparam logic [0:0] IDLE = 1'b0;
      localparam logic [0:0] BUSY = 1'b1;

      logic [0:0]    state_reg, state_next;
      logic [CW-1:0] cnt_reg, cnt_next;
      logic [DW-1:0] acc_reg, acc_next;
      logic          done_reg, done_next;
      logic          is_mul;
      logic [CW-1:0] step_idx;
      logic [DW-1:0] step_base;
      logic [DW-1:0] step_sum;

      assign is_mul = (aluc_reg == 4'd12);

      // Bit 0 is accumulated on the IDLE->BUSY edge from a zero accumulator,
      // so the DW-th step lands on the last stall cycle.
      always_comb begin
        step_idx  = (state_reg == BUSY) ? cnt_reg : '0;
        step_base = (state_reg == BUSY) ? acc_reg : '0;
        step_sum  = step_base + (b_op[step_idx] ? (a_op << step_idx) : '0);
      end

      always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        acc_next   = acc_reg;
        done_next  = done_reg;
        case (state_reg)
          IDLE: begin
            if (done_reg) begin
              done_next = 1'b0;
            end else if (is_mul) begin
              acc_next   = step_sum;
              cnt_next   = CW'(1);
              state_next = BUSY;
            end
          end
          default: begin
            acc_next = step_sum;
            cnt_next = cnt_reg + CW'(1);
            if (cnt_reg == CW'(DW - 1)) begin
              cnt_next   = '0;
              state_next = IDLE;
              done_next  = 1'b1;
            end
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
          acc_reg   <= '0;
          done_reg  <= 1'b0;
        end else begin
          state_reg <= state_next;
          cnt_reg   <= cnt_next;
          acc_reg   <= acc_next;
          done_reg  <= done_next;
        end
      end

      assign mul_stall  = (state_reg == BUSY) | (is_mul & ~done_reg);
      assign mul_result = acc_reg;
    end else begin : g_no_mul
      assign mul_stall  = 1'b0;
      assign mul_result = '0;
    end
  endgenerate

  assign ex_stall       = mul_stall;
  assign ex_destR       = dest_reg;
  assign ex_inB         = inb_reg;
  assign ex_aluR        = alu_result;
  assign ex_wreg        = wreg_reg & ~mul_stall;
  assign ex_m2reg       = m2reg_reg & ~mul_stall;
  assign ex_wmem        = wmem_reg & ~mul_stall;
  assign EXE_ins_type   = type_reg;
  assign EXE_ins_number = num_reg;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a driver pushes model results per issued
// instruction, a negedge monitor pops them whenever the stage is not stalled.
module tb_exe_stage;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [4:0]    id_destR = '0;
  logic [DW-1:0] id_inA = '0, id_inB = '0, id_imm = '0;
  logic [3:0]    id_aluc = '0;
  logic          id_aluimm = 1'b0, id_wreg = 1'b0, id_m2reg = 1'b0, id_wmem = 1'b0;
  logic [3:0]    ID_ins_type = '0, ID_ins_number = '0;
  logic [4:0]    ex_destR;
  logic [DW-1:0] ex_inB, ex_aluR;
  logic          ex_wreg, ex_m2reg, ex_wmem, ex_stall;
  logic [3:0]    EXE_ins_type, EXE_ins_number;

  exe_stage #(.DW(DW), .ENABLE_MUL(1)) dut (
    .clk(clk), .rst(rst),
    .id_destR(id_destR), .id_inA(id_inA), .id_inB(id_inB), .id_imm(id_imm),
    .id_aluc(id_aluc), .id_aluimm(id_aluimm), .id_wreg(id_wreg),
    .id_m2reg(id_m2reg), .id_wmem(id_wmem),
    .ID_ins_type(ID_ins_type), .ID_ins_number(ID_ins_number),
    .ex_destR(ex_destR), .ex_inB(ex_inB), .ex_aluR(ex_aluR),
    .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_wmem(ex_wmem),
    .EXE_ins_type(EXE_ins_type), .EXE_ins_number(EXE_ins_number),
    .ex_stall(ex_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]    aluc;
    logic [DW-1:0] alur;
    logic [DW-1:0] inb;
    logic [4:0]    dest;
    logic          wreg, m2reg, wmem;
    logic [3:0]    typ, num;
    int            stall;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn_no = 0;
  int   stall_cnt = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference ALU in plain arithmetic; MUL is just the truncated product.
  function automatic logic [DW-1:0] ref_alu(input logic [3:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    logic [4:0]    sh;
    logic [DW-1:0] ones;
    sh   = a[4:0];
    ones = '1;
    case (op)
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return ~(a | b);
      4'd6:  return ($signed(a) < $signed(b)) ? 1 : 0;
      4'd7:  return (a < b) ? 1 : 0;
      4'd8:  return b << sh;
      4'd9:  return b >> sh;
      4'd10: return (b >> sh) | (b[DW-1] ? ~(ones >> sh) : '0);
      4'd11: return b * 32'h10000;
      4'd12: return a * b;
      default: return a + b;
    endcase
  endfunction

  function automatic exp_t nop_exp();
    exp_t e;
    e = '{aluc: 4'd0, alur: '0, inb: '0, dest: '0, wreg: 1'b0, m2reg: 1'b0, wmem: 1'b0,
          typ: '0, num: '0, stall: 0};
    return e;
  endfunction

  // Waits for a non-stalled negedge, drives the instruction, pushes its expectation.
  task automatic run_txn(input logic [3:0] aluc, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [DW-1:0] imm, input logic aluimm, input logic [4:0] dest,
                         input logic wreg, input logic m2reg, input logic wmem,
                         input logic [3:0] typ, input logic [3:0] num);
    exp_t e;
    int   w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (ex_stall && w < 100);
    if (ex_stall) begin
      checks++;
      errors++;
      $display("FAIL stall_timeout: ex_stall still 1 after %0d cycles", w);
      return;
    end
    id_aluc = aluc; id_inA = a; id_inB = b; id_imm = imm; id_aluimm = aluimm;
    id_destR = dest; id_wreg = wreg; id_m2reg = m2reg; id_wmem = wmem;
    ID_ins_type = typ; ID_ins_number = num;
    e.aluc  = aluc;
    e.alur  = ref_alu(aluc, a, aluimm ? imm : b);
    e.inb   = b;
    e.dest  = dest;
    e.wreg  = wreg; e.m2reg = m2reg; e.wmem = wmem;
    e.typ   = typ; e.num = num;
    e.stall = (aluc == 4'd12) ? DW : 0;
    q.push_back(e);
  endtask

  task automatic run_nop();
    run_txn(4'd0, '0, '0, '0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic drive_nop_inputs();
    id_aluc = '0; id_inA = '0; id_inB = '0; id_imm = '0; id_aluimm = 1'b0;
    id_destR = '0; id_wreg = 1'b0; id_m2reg = 1'b0; id_wmem = 1'b0;
    ID_ins_type = '0; ID_ins_number = '0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_aluR"}, 64'(ex_aluR), 64'd0);
    chk({tag, "_inB"}, 64'(ex_inB), 64'd0);
    chk({tag, "_dest"}, 64'(ex_destR), 64'd0);
    chk({tag, "_ctl"}, 64'({ex_wreg, ex_m2reg, ex_wmem}), 64'd0);
    chk({tag, "_tags"}, 64'({EXE_ins_type, EXE_ins_number}), 64'd0);
    chk({tag, "_stall"}, 64'(ex_stall), 64'd0);
  endtask

  task automatic start_monitor();
    @(posedge clk);
    #1;
    q.delete();
    q.push_back(nop_exp());
    stall_cnt = 0;
    mon_en = 1'b1;
  endtask

  task automatic stop_monitor();
    run_nop();
    run_nop();
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    q.delete();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (ex_stall) begin
        stall_cnt++;
        chk("stall_masked_ctl", 64'({ex_wreg, ex_m2reg, ex_wmem}), 64'd0);
      end else begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: output presented with no expectation at %0t", $time);
        end else begin
          e = q.pop_front();
          chk("aluR", 64'(ex_aluR), 64'(e.alur));
          chk("inB", 64'(ex_inB), 64'(e.inb));
          chk("destR", 64'(ex_destR), 64'(e.dest));
          chk("ctl", 64'({ex_wreg, ex_m2reg, ex_wmem}), 64'({e.wreg, e.m2reg, e.wmem}));
          chk("tags", 64'({EXE_ins_type, EXE_ins_number}), 64'({e.typ, e.num}));
          chk("stall_len", 64'(stall_cnt), 64'(e.stall));
          $display("txn %0d aluc=%0d aluR=%h exp=%h stall=%0d", txn_no, e.aluc, ex_aluR,
                   e.alur, stall_cnt);
          txn_no++;
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    // Reset held with random inputs, then released between edges.
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      id_inA = $urandom; id_inB = $urandom; id_imm = $urandom; id_aluc = 4'($urandom);
      id_destR = 5'($urandom); id_wreg = 1'b1; id_wmem = 1'b1; id_m2reg = 1'b1;
      ID_ins_type = 4'($urandom); ID_ins_number = 4'($urandom);
      #1 check_all_zero("reset_hold");
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("reset_release");
    drive_nop_inputs();

    start_monitor();
    run_txn(4'd0, 32'h7FFFFFFF, 32'hCAFEF00D, 32'd1, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 4'd1, 4'd1);
    run_txn(4'd6, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 4'd2, 4'd2);
    run_txn(4'd7, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3);
    run_txn(4'd10, 32'd4, 32'h80000000, 32'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 4'd3, 4'd4);
    run_txn(4'd11, 32'd0, 32'd0, 32'h00001234, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 4'd4, 4'd5);
    run_txn(4'd12, 32'd1234, 32'd5678, 32'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 4'd5, 4'd6);
    run_txn(4'd0, 32'd10, 32'd20, 32'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 4'd1, 4'd7);
    run_txn(4'd12, 32'hFFFFFFFF, 32'h12345679, 32'd0, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 4'd5, 4'd8);
    run_txn(4'd12, 32'd3, 32'd0, 32'hFFFFFFF9, 1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 4'd5, 4'd9);
    run_txn(4'd0, 32'h00001000, 32'hDEADBEEF, 32'h00000010, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1,
            4'd6, 4'd10);
    for (int i = 0; i < 150; i++) begin
      run_txn(4'($urandom), $urandom, $urandom, $urandom, 1'($urandom), 5'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom));
    end
    stop_monitor();

    // Abandon a multiply with reset at busy cycle 10.
    @(negedge clk);
    id_aluc = 4'd12; id_inA = 32'd77; id_inB = 32'd99; id_aluimm = 1'b0;
    id_wreg = 1'b1; id_destR = 5'd12; ID_ins_type = 4'd5; ID_ins_number = 4'd11;
    @(posedge clk);
    #1 drive_nop_inputs();
    repeat (11) @(negedge clk);
    chk("busy_before_reset", 64'(ex_stall), 64'd1);
    #2 rst = 1'b0;
    #1 check_all_zero("reset_mid_mul");
    @(negedge clk);
    #2 rst = 1'b1;
    start_monitor();
    run_txn(4'd12, 32'd1234, 32'd5678, 32'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 4'd5, 4'd12);
    run_txn(4'd0, 32'd1, 32'd2, 32'd0, 1'b0, 5'd14, 1'b1, 1'b0, 1'b0, 4'd1, 4'd13);
    stop_monitor();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
